// File: rtl/qpsk_pkg.sv
// Shared QPSK constants: carrier LUT, dibit mapping, accumulator sizing and demod FSM states.
package qpsk_pkg;

    // Bit value carried by a positive amplitude (same mapping as the modulator).
    localparam logic DIBIT_POS = 1'b1;

    typedef enum logic [1:0] {HUNT, ACC, DUMP} demod_state_t;

    function automatic logic signed [7:0] cos_lut(input logic [2:0] k);
        case (k)
            3'd0:    cos_lut = 8'sd127;
            3'd1:    cos_lut = 8'sd90;
            3'd2:    cos_lut = 8'sd0;
            3'd3:    cos_lut = -8'sd90;
            3'd4:    cos_lut = -8'sd127;
            3'd5:    cos_lut = -8'sd90;
            3'd6:    cos_lut = 8'sd0;
            default: cos_lut = 8'sd90;
        endcase
    endfunction

    function automatic logic signed [7:0] sin_lut(input logic [2:0] k);
        case (k)
            3'd0:    sin_lut = 8'sd0;
            3'd1:    sin_lut = 8'sd90;
            3'd2:    sin_lut = 8'sd127;
            3'd3:    sin_lut = 8'sd90;
            3'd4:    sin_lut = 8'sd0;
            3'd5:    sin_lut = -8'sd90;
            3'd6:    sin_lut = -8'sd127;
            default: sin_lut = -8'sd90;
        endcase
    endfunction

    // Wide enough to sum sym_len full-scale products without overflow.
    function automatic int acc_width(input int sample_w, input int sym_len);
        return sample_w + 8 + $clog2(sym_len);
    endfunction

endpackage

// File: rtl/qpsk_nco.sv
// Carrier phase counter with cos/sin lookup; clr forces phase 0 for the sample presented with it.
import qpsk_pkg::*;

module qpsk_nco #(
    parameter int CARR_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic              clr,
    output logic signed [7:0] cos_o,
    output logic signed [7:0] sin_o
);
    localparam int PH_W = $clog2(CARR_LEN);
    localparam logic [PH_W-1:0] PH_MAX = PH_W'(CARR_LEN - 1);

    logic [PH_W-1:0] phase;
    logic [PH_W-1:0] phase_cur;

    assign phase_cur = clr ? '0 : phase;
    assign cos_o     = cos_lut(3'(phase_cur));
    assign sin_o     = sin_lut(3'(phase_cur));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (adv) begin
            phase <= (phase_cur == PH_MAX) ? '0 : phase_cur + PH_W'(1);
        end else if (clr) begin
            phase <= '0;
        end
    end

endmodule

// File: rtl/qpsk_demod.sv
// Coherent QPSK demodulator: NCO mix, integrate-and-dump per symbol, dibit slicing into parallel words.
import qpsk_pkg::*;

module qpsk_demod #(
    parameter int SAMPLE_W   = 29,
    parameter int SYM_LEN    = 32,
    parameter int CARR_LEN   = 8,
    parameter int FRAME_BITS = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SAMPLE_W-1:0]   qpsk,
    input  logic                  in_valid,
    input  logic                  sync,
    output logic [FRAME_BITS-1:0] para_out,
    output logic                  out_valid,
    output logic [7:0]            sym_cnt_o
);
    // state | meaning
    // HUNT  | idle after reset, waiting for the first sample
    // ACC   | integrating products of the current symbol
    // DUMP  | slice last symbol, shift dibit, emit word on frame end

    localparam int PROD_W = SAMPLE_W + 8;
    localparam int ACC_W  = acc_width(SAMPLE_W, SYM_LEN);
    localparam int CNT_W  = $clog2(SYM_LEN);
    localparam int DIBITS = FRAME_BITS / 2;
    localparam int DC_W   = $clog2(DIBITS);

    logic signed [SAMPLE_W-1:0] qpsk_s;
    logic signed [7:0]          cos_w, sin_w;
    logic signed [PROD_W-1:0]   mul_i, mul_q, prod_i, prod_q;
    logic signed [ACC_W-1:0]    prod_i_x, prod_q_x, acc_i, acc_q;
    logic                       prod_vld;
    logic [1:0]                 dibit;
    demod_state_t               state;
    logic [CNT_W-1:0]           samp_cnt;
    logic [DC_W-1:0]            dib_cnt;
    logic [FRAME_BITS-1:0]      shreg;

    qpsk_nco #(.CARR_LEN(CARR_LEN)) u_nco (
        .clk   (clk),
        .rst   (rst),
        .adv   (in_valid),
        .clr   (sync),
        .cos_o (cos_w),
        .sin_o (sin_w)
    );

    assign qpsk_s   = qpsk;
    assign mul_i    = PROD_W'(qpsk_s) * PROD_W'(cos_w);
    assign mul_q    = -(PROD_W'(qpsk_s) * PROD_W'(sin_w));
    assign prod_i_x = ACC_W'(prod_i);
    assign prod_q_x = ACC_W'(prod_q);
    assign dibit    = {acc_i[ACC_W-1] ? ~DIBIT_POS : DIBIT_POS,
                       acc_q[ACC_W-1] ? ~DIBIT_POS : DIBIT_POS};
    assign sym_cnt_o = 8'(dib_cnt);

    // Product register holds its value across input gaps; prod_vld marks a fresh product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_i   <= '0;
            prod_q   <= '0;
            prod_vld <= 1'b0;
        end else begin
            prod_vld <= in_valid;
            if (in_valid) begin
                prod_i <= mul_i;
                prod_q <= mul_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            samp_cnt  <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            dib_cnt   <= '0;
            shreg     <= '0;
            para_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (sync) begin
                state    <= ACC;
                samp_cnt <= '0;
                acc_i    <= '0;
                acc_q    <= '0;
                dib_cnt  <= '0;
                shreg    <= '0;
            end else begin
                case (state)
                    HUNT: begin
                        if (in_valid) state <= ACC;
                    end
                    ACC: begin
                        if (prod_vld) begin
                            acc_i <= acc_i + prod_i_x;
                            acc_q <= acc_q + prod_q_x;
                            if (samp_cnt == CNT_W'(SYM_LEN - 1)) begin
                                samp_cnt <= '0;
                                state    <= DUMP;
                            end else begin
                                samp_cnt <= samp_cnt + CNT_W'(1);
                            end
                        end
                    end
                    DUMP: begin
                        // Reload with the next symbol's first product so no sample is lost.
                        acc_i    <= prod_vld ? prod_i_x : '0;
                        acc_q    <= prod_vld ? prod_q_x : '0;
                        samp_cnt <= prod_vld ? CNT_W'(1) : '0;
                        state    <= ACC;
                        if (dib_cnt == DC_W'(DIBITS - 1)) begin
                            para_out  <= {shreg[FRAME_BITS-3:0], dibit};
                            out_valid <= 1'b1;
                            shreg     <= '0;
                            dib_cnt   <= '0;
                        end else begin
                            shreg   <= {shreg[FRAME_BITS-3:0], dibit};
                            dib_cnt <= dib_cnt + DC_W'(1);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qpsk_demod.sv
// Randomized scoreboard bench for qpsk_demod against an arithmetic correlate-and-slice reference.
import qpsk_pkg::*;

module tb_qpsk_demod;
    localparam int SAMPLE_W   = 29;
    localparam int SYM_LEN    = 32;
    localparam int CARR_LEN   = 8;
    localparam int FRAME_BITS = 40;
    localparam int DIBITS     = FRAME_BITS / 2;
    localparam int PER        = 20;
    localparam int AMP        = 1 << 20;
    localparam real PI        = 3.14159265358979;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [SAMPLE_W-1:0]   qpsk;
    logic                  in_valid;
    logic                  sync;
    logic [FRAME_BITS-1:0] para_out;
    logic                  out_valid;
    logic [7:0]            sym_cnt_o;

    qpsk_demod #(
        .SAMPLE_W   (SAMPLE_W),
        .SYM_LEN    (SYM_LEN),
        .CARR_LEN   (CARR_LEN),
        .FRAME_BITS (FRAME_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .qpsk      (qpsk),
        .in_valid  (in_valid),
        .sync      (sync),
        .para_out  (para_out),
        .out_valid (out_valid),
        .sym_cnt_o (sym_cnt_o)
    );

    always #(PER / 2) clk = ~clk;

    typedef struct {
        logic [FRAME_BITS-1:0] word;
        longint                t_due;
    } exp_t;

    exp_t                  sb[$];
    int                    errors = 0;
    int                    checks = 0;
    int                    words_exp = 0;
    int                    words_seen = 0;
    logic [FRAME_BITS-1:0] last_word = '0;

    int                    lut_c[CARR_LEN];
    int                    lut_s[CARR_LEN];
    longint                m_si, m_sq;
    int                    m_n, m_ph, m_dib;
    logic [FRAME_BITS-1:0] m_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_si = 0; m_sq = 0; m_n = 0; m_ph = 0; m_dib = 0; m_word = '0;
    endtask

    // Correlate against the ideal carrier, slice sign at symbol end, pack MSB-first.
    task automatic model_accept(input longint s, input longint t);
        m_si += s * lut_c[m_ph];
        m_sq += -s * lut_s[m_ph];
        m_ph = (m_ph + 1) % CARR_LEN;
        m_n++;
        if (m_n == SYM_LEN) begin
            m_word = {m_word[FRAME_BITS-3:0], (m_si >= 0), (m_sq >= 0)};
            m_si = 0; m_sq = 0; m_n = 0;
            m_dib++;
            if (m_dib == DIBITS) begin
                sb.push_back('{m_word, t + 2 * PER + PER / 2});
                words_exp++;
                m_dib = 0;
                m_word = '0;
            end
        end
    endtask

    task automatic step(input longint s, input logic v, input logic sy);
        qpsk = SAMPLE_W'(s);
        in_valid = v;
        sync = sy;
        @(posedge clk);
        if (sy) model_clear();
        if (v) model_accept(s, $time);
        #1;
        in_valid = 1'b0;
        sync = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0);
    endtask

    task automatic send_symbol(input int ai, input int aq, input int gap_pct, input logic sy);
        int     k;
        longint s;
        for (int n = 0; n < SYM_LEN; n++) begin
            while ($urandom_range(99, 0) < gap_pct) step(0, 1'b0, 1'b0);
            k = (sy && n == 0) ? 0 : m_ph;
            s = longint'(ai) * lut_c[k] - longint'(aq) * lut_s[k];
            step(s, 1'b1, sy && n == 0);
        end
    endtask

    task automatic send_word(input logic [FRAME_BITS-1:0] w, input int gap_pct, input logic sy);
        for (int d = 0; d < DIBITS; d++)
            send_symbol(w[FRAME_BITS-1-2*d] ? AMP : -AMP, w[FRAME_BITS-2-2*d] ? AMP : -AMP,
                        gap_pct, sy && d == 0);
    endtask

    function automatic int rand_amp();
        int m;
        if ($urandom_range(9, 0) == 0) return 0;
        m = int'($urandom_range(AMP, 1));
        return ($urandom_range(1, 0) == 1) ? m : -m;
    endfunction

    task automatic send_random(input int nsym, input int gap_pct);
        for (int d = 0; d < nsym; d++) send_symbol(rand_amp(), rand_amp(), gap_pct, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid) begin
                words_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected no output", para_out);
                end else begin
                    e = sb.pop_front();
                    check("word", para_out, e.word);
                    check("latency", $time, e.t_due);
                    last_word = e.word;
                end
            end else begin
                check("hold", para_out, last_word);
            end
        end
    end

    initial begin
        for (int k = 0; k < CARR_LEN; k++) begin
            lut_c[k] = int'($floor(127.0 * $cos(2.0 * PI * k / CARR_LEN) + 0.5));
            lut_s[k] = int'($floor(127.0 * $sin(2.0 * PI * k / CARR_LEN) + 0.5));
        end
        model_clear();
        rst = 1'b1; qpsk = '0; in_valid = 1'b0; sync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_para_out", para_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sym_cnt", sym_cnt_o, 0);
        check("rst_state", dut.state, HUNT);
        rst = 1'b0;
        idle(2);

        // Loopback-style frames, back to back, then with 50% gaps.
        send_word(40'hFF_17_18_19_FF, 0, 1'b1);
        send_word(40'hFF_17_18_19_FF, 0, 1'b0);
        idle(4);
        check("loopback_word", para_out, 40'hFF171819FF);
        send_word(40'hFF_17_18_19_FF, 50, 1'b0);
        idle(4);
        check("gap_word", para_out, 40'hFF171819FF);

        // Pure cosine carrier and zero input both slice to all ones.
        for (int d = 0; d < DIBITS; d++) send_symbol(AMP, 0, 0, 1'b0);
        idle(4);
        check("cos_word", para_out, 40'hFFFFFFFFFF);
        send_word(40'h0123456789, 0, 1'b0);
        for (int d = 0; d < DIBITS; d++) send_symbol(0, 0, 10, 1'b0);
        idle(4);
        check("zero_word", para_out, 40'hFFFFFFFFFF);

        send_random(2 * DIBITS, 25);
        idle(4);

        // Sync after 7 dibits discards the partial frame.
        send_random(7, 0);
        idle(3);
        check("pre_sync_cnt", sym_cnt_o, 7);
        step(0, 1'b0, 1'b1);
        check("post_sync_cnt", sym_cnt_o, 0);
        idle(3);
        send_random(DIBITS, 20);
        idle(4);

        // Reset in the middle of dibit 12.
        send_random(12, 0);
        idle(3);
        check("pre_rst_cnt", sym_cnt_o, 12);
        for (int n = 0; n < 5; n++) step(longint'(rand_amp()) * 100, 1'b1, 1'b0);
        rst = 1'b1;
        model_clear();
        words_exp -= sb.size();
        sb.delete();
        last_word = '0;
        #1;
        check("midrst_para_out", para_out, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sym_cnt", sym_cnt_o, 0);
        check("midrst_state", dut.state, HUNT);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        send_word(40'hA5_3C_0F_96_E1, 0, 1'b0);
        idle(4);
        check("post_rst_word", para_out, 40'hA53C0F96E1);
        send_random(DIBITS, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
        idle(2);
        check("scoreboard_empty", sb.size(), 0);
        check("word_count", words_seen, words_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
